// File: rtl/iex_comp_arbiter.sv
// iex_comp_arbiter: round-robin shared set-less-than comparator with a single registered result slot
module iex_comp_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int TAG_WIDTH  = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req0_valid,
  output logic                  req0_ready,
  input  logic [DATA_WIDTH-1:0] req0_a,
  input  logic [DATA_WIDTH-1:0] req0_b,
  input  logic                  req0_unsigned,
  input  logic [TAG_WIDTH-1:0]  req0_tag,
  input  logic                  req1_valid,
  output logic                  req1_ready,
  input  logic [DATA_WIDTH-1:0] req1_a,
  input  logic [DATA_WIDTH-1:0] req1_b,
  input  logic                  req1_unsigned,
  input  logic [TAG_WIDTH-1:0]  req1_tag,
  output logic                  rsp0_valid,
  input  logic                  rsp0_ready,
  output logic                  rsp1_valid,
  input  logic                  rsp1_ready,
  output logic                  rsp_lt,
  output logic [TAG_WIDTH-1:0]  rsp_tag
);
  typedef enum logic [1:0] {EMPTY, FULL0, FULL1} slot_t;
  slot_t state, state_nxt;
  logic last_grant, grant0, grant1, drain, can_accept, acc0, acc1, lt;
  logic [DATA_WIDTH-1:0] a, b;
  // last_grant holds the index of the most recently served requester
  assign grant0 = req0_valid & (~req1_valid | last_grant);
  assign grant1 = req1_valid & (~req0_valid | ~last_grant);
  assign drain = (state == FULL0 & rsp0_ready) | (state == FULL1 & rsp1_ready);
  assign can_accept = ~rst & (state == EMPTY | drain);
  assign req0_ready = can_accept & grant0;
  assign req1_ready = can_accept & grant1;
  assign acc0 = req0_valid & req0_ready;
  assign acc1 = req1_valid & req1_ready;
  assign a = grant1 ? req1_a : req0_a;
  assign b = grant1 ? req1_b : req0_b;
  assign lt = (grant1 ? req1_unsigned : req0_unsigned) ? (a < b) : ($signed(a) < $signed(b));
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= EMPTY;
      last_grant <= 1'b1;
      rsp_lt     <= 1'b0;
      rsp_tag    <= '0;
    end else begin
      state <= state_nxt;
      if (acc0 | acc1) begin
        last_grant <= acc1;
        rsp_lt     <= lt;
        rsp_tag    <= acc1 ? req1_tag : req0_tag;
      end
    end
  end
  always_comb begin
    state_nxt = acc0 ? FULL0 : acc1 ? FULL1 : drain ? EMPTY : state;
  end
  always_comb begin
    rsp0_valid = state == FULL0;
    rsp1_valid = state == FULL1;
  end
endmodule

// File: tb/tb_iex_comp_arbiter.sv
// tb_iex_comp_arbiter: directed vector table plus multi-cycle arbitration, backpressure and reset sequences
module tb_iex_comp_arbiter;
  logic clk = 0, rst = 1;
  logic req0_valid = 0, req1_valid = 0, req0_unsigned = 0, req1_unsigned = 0;
  logic [31:0] req0_a = 0, req0_b = 0, req1_a = 0, req1_b = 0;
  logic [4:0] req0_tag = 0, req1_tag = 0;
  logic rsp0_ready = 1, rsp1_ready = 1;
  logic req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_lt;
  logic [4:0] rsp_tag;
  int checks = 0, errors = 0;

  iex_comp_arbiter dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
    .req0_unsigned(req0_unsigned), .req0_tag(req0_tag),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
    .req1_unsigned(req1_unsigned), .req1_tag(req1_tag),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
    .rsp_lt(rsp_lt), .rsp_tag(rsp_tag)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit k;
    logic [31:0] a, b;
    bit u;
    logic [4:0] tag;
    bit lt;
  } vec_t;
  vec_t vt[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    vt[0] = '{0, 32'hFFFFFFFF, 32'h1, 0, 5'd3, 1};
    vt[1] = '{1, 32'hFFFFFFFF, 32'h1, 1, 5'd7, 0};
    vt[2] = '{0, 32'h80000000, 32'h80000000, 0, 5'd1, 0};
    vt[3] = '{1, 32'h80000000, 32'h80000000, 1, 5'd2, 0};
    vt[4] = '{0, 32'h7FFFFFFF, 32'h80000000, 0, 5'd4, 0};
    vt[5] = '{1, 32'h7FFFFFFF, 32'h80000000, 1, 5'd5, 1};
    vt[6] = '{0, 32'd5, 32'd9, 0, 5'd6, 1};
    vt[7] = '{1, 32'd9, 32'd5, 1, 5'd8, 0};
    vt[8] = '{0, 32'h0, 32'hFFFFFFFF, 1, 5'd30, 1};
    vt[9] = '{1, 32'h0, 32'hFFFFFFFF, 0, 5'd31, 0};

    step();
    #1;
    check("rst_req0_ready", req0_ready, 0);
    check("rst_rsp0_valid", rsp0_valid, 0);
    check("rst_rsp1_valid", rsp1_valid, 0);
    check("rst_rsp_lt", rsp_lt, 0);
    check("rst_rsp_tag", rsp_tag, 0);
    rst = 0;

    foreach (vt[i]) begin
      req0_valid = !vt[i].k; req1_valid = vt[i].k;
      req0_a = vt[i].a; req0_b = vt[i].b; req0_unsigned = vt[i].u; req0_tag = vt[i].tag;
      req1_a = vt[i].a; req1_b = vt[i].b; req1_unsigned = vt[i].u; req1_tag = vt[i].tag;
      #1;
      check($sformatf("v%0d_req0_ready", i), req0_ready, !vt[i].k);
      check($sformatf("v%0d_req1_ready", i), req1_ready, vt[i].k);
      step();
      req0_valid = 0; req1_valid = 0;
      check($sformatf("v%0d_rsp0_valid", i), rsp0_valid, !vt[i].k);
      check($sformatf("v%0d_rsp1_valid", i), rsp1_valid, vt[i].k);
      check($sformatf("v%0d_rsp_lt", i), rsp_lt, vt[i].lt);
      check($sformatf("v%0d_rsp_tag", i), rsp_tag, vt[i].tag);
    end

    // round robin from a fresh reset: 0,1,0,1 back to back
    rst = 1;
    step();
    rst = 0;
    req0_a = 1; req0_b = 2; req0_unsigned = 0; req0_tag = 10;
    req1_a = 2; req1_b = 1; req1_unsigned = 0; req1_tag = 20;
    req0_valid = 1; req1_valid = 1;
    for (int i = 0; i < 4; i++) begin
      #1;
      check($sformatf("rr%0d_req0_ready", i), req0_ready, i % 2 == 0);
      check($sformatf("rr%0d_req1_ready", i), req1_ready, i % 2 == 1);
      step();
      check($sformatf("rr%0d_rsp_tag", i), rsp_tag, i % 2 ? 20 : 10);
      check($sformatf("rr%0d_rsp_lt", i), rsp_lt, i % 2 == 0);
      check($sformatf("rr%0d_rsp0_valid", i), rsp0_valid, i % 2 == 0);
    end
    req0_valid = 0; req1_valid = 0;

    // backpressure on FULL0, then same-cycle drain and refill
    rsp0_ready = 0;
    req0_valid = 1; req0_a = 32'hFFFFFFFF; req0_b = 1; req0_unsigned = 0; req0_tag = 12;
    #1;
    check("bp_req0_ready", req0_ready, 1);
    step();
    req0_valid = 0;
    req1_valid = 1; req1_a = 3; req1_b = 4; req1_unsigned = 1; req1_tag = 9;
    for (int i = 0; i < 3; i++) begin
      #1;
      check($sformatf("bp%0d_req1_ready", i), req1_ready, 0);
      check($sformatf("bp%0d_rsp0_valid", i), rsp0_valid, 1);
      check($sformatf("bp%0d_rsp_lt", i), rsp_lt, 1);
      check($sformatf("bp%0d_rsp_tag", i), rsp_tag, 12);
      step();
    end
    rsp0_ready = 1;
    #1;
    check("bp_refill_req1_ready", req1_ready, 1);
    step();
    req1_valid = 0;
    rsp1_ready = 0;
    check("bp_rsp1_valid", rsp1_valid, 1);
    check("bp_rsp0_valid", rsp0_valid, 0);
    check("bp_rsp_tag", rsp_tag, 9);
    check("bp_rsp_lt", rsp_lt, 1);

    // reset with FULL1 held; a request during reset is ignored
    rst = 1;
    req0_valid = 1; req0_tag = 17;
    #1;
    check("mid_rst_req0_ready", req0_ready, 0);
    step();
    rst = 0; req0_valid = 0;
    check("post_rst_rsp0_valid", rsp0_valid, 0);
    check("post_rst_rsp1_valid", rsp1_valid, 0);
    check("post_rst_rsp_lt", rsp_lt, 0);
    check("post_rst_rsp_tag", rsp_tag, 0);
    rsp1_ready = 1;
    req0_valid = 1; req1_valid = 1;
    #1;
    check("post_rst_req0_ready", req0_ready, 1);
    check("post_rst_req1_ready", req1_ready, 0);
    step();
    req0_valid = 0; req1_valid = 0;
    check("post_rst_grant0_valid", rsp0_valid, 1);
    check("post_rst_grant0_tag", rsp_tag, 17);
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
